// File: rtl/width_conv_fifo.sv
// width_conv_fifo: packs RATIO narrow write words into one wide read word.
// Define WCFIFO_OUTPUT_REG_EN to add a second read output register stage.
module width_conv_fifo #(
    parameter int WR_WIDTH = 8,
    parameter int RATIO = 32,
    parameter int DEPTH_W = 10,
    parameter int MSB_FIRST = 0,
    parameter int AF_NUM = 1000,
    parameter int AE_NUM = 4,
    localparam int LOG_R = $clog2(RATIO),
    localparam int RD_WIDTH = WR_WIDTH * RATIO,
    localparam int RD_DEPTH_W = DEPTH_W - LOG_R
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WR_WIDTH-1:0]   wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic [DEPTH_W:0]      wr_level,
    input  logic                  rd_en,
    output logic [RD_WIDTH-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [RD_DEPTH_W:0]   rd_level,
    output logic                  overflow,
    output logic                  underflow
);
    logic [WR_WIDTH-1:0] r_mem [RATIO][2**RD_DEPTH_W];
    logic [DEPTH_W:0]    r_wp;
    logic [RD_DEPTH_W:0] r_rp;
    logic [RD_WIDTH-1:0] r_data;
    logic                r_valid;
    logic                r_ovf;
    logic                r_unf;
    logic [RD_WIDTH-1:0] w_row;
    logic                w_wr_acc;
    logic                w_rd_acc;
    assign wr_level     = r_wp - {r_rp, {LOG_R{1'b0}}};
    assign rd_level     = wr_level[DEPTH_W:LOG_R];
    assign wr_full      = wr_level == {1'b1, {DEPTH_W{1'b0}}};
    assign almost_full  = wr_level >= (DEPTH_W+1)'(AF_NUM);
    assign rd_empty     = rd_level == '0;
    assign almost_empty = rd_level <= (RD_DEPTH_W+1)'(AE_NUM);
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign w_wr_acc     = wr_en && !wr_full && !flush;
    assign w_rd_acc     = rd_en && !rd_empty && !flush;
    // Bank g holds the g-th written word of each row; MSB_FIRST mirrors slice placement.
    for (genvar g = 0; g < RATIO; g++) begin : g_pack
        assign w_row[(MSB_FIRST != 0 ? RATIO-1-g : g)*WR_WIDTH +: WR_WIDTH] = r_mem[g][r_rp[RD_DEPTH_W-1:0]];
    end
    always_ff @(posedge clk)
        if (w_wr_acc)
            r_mem[r_wp[LOG_R-1:0]][r_wp[DEPTH_W-1:LOG_R]] <= wr_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (flush) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_wr_acc)
                    r_wp <= r_wp + 1'b1;
                if (w_rd_acc) begin
                    r_rp   <= r_rp + 1'b1;
                    r_data <= w_row;
                end
                if (wr_en && wr_full)
                    r_ovf <= 1'b1;
                if (rd_en && rd_empty)
                    r_unf <= 1'b1;
            end
        end
`ifdef WCFIFO_OUTPUT_REG_EN
    logic [RD_WIDTH-1:0] r_data_q;
    logic                r_valid_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= r_data;
            r_valid_q <= r_valid;
        end
    assign rd_data  = r_data_q;
    assign rd_valid = r_valid_q;
`else
    assign rd_data  = r_data;
    assign rd_valid = r_valid;
`endif
endmodule

// File: tb/tb_width_conv_fifo.sv
// tb_width_conv_fifo: queue-model checked bench driving an LSB-first and an MSB-first instance in parallel.
module tb_width_conv_fifo;
`ifdef WCFIFO_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic clk, rst_n, flush, wr_en, rd_en;
    logic [7:0] wr_data;
    logic l_full, l_af, l_empty, l_ae, l_valid, l_ovf, l_unf;
    logic m_full, m_af, m_empty, m_ae, m_valid, m_ovf_o, m_unf_o;
    logic [4:0] l_wl, m_wl;
    logic [2:0] l_rl, m_rl;
    logic [31:0] l_data, m_data;
    int pass_cnt = 0, total_cnt = 0;

    width_conv_fifo #(.WR_WIDTH(8), .RATIO(4), .DEPTH_W(4), .MSB_FIRST(0), .AF_NUM(14), .AE_NUM(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(l_full), .almost_full(l_af), .wr_level(l_wl), .rd_en(rd_en), .rd_data(l_data),
        .rd_valid(l_valid), .rd_empty(l_empty), .almost_empty(l_ae), .rd_level(l_rl),
        .overflow(l_ovf), .underflow(l_unf));
    width_conv_fifo #(.WR_WIDTH(8), .RATIO(4), .DEPTH_W(4), .MSB_FIRST(1), .AF_NUM(14), .AE_NUM(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(m_full), .almost_full(m_af), .wr_level(m_wl), .rd_en(rd_en), .rd_data(m_data),
        .rd_valid(m_valid), .rd_empty(m_empty), .almost_empty(m_ae), .rd_level(m_rl),
        .overflow(m_ovf_o), .underflow(m_unf_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Model: a queue of stored write words; a read word is four words popped oldest-first.
    logic [7:0] mq[$];
    logic [31:0] md1, md2;
    bit mv1, mv2, movf, munf;
    int mn;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            md1 = 0; md2 = 0; mv1 = 0; mv2 = 0; movf = 0; munf = 0;
        end else begin
            mn = mq.size();
            md2 = md1; mv2 = mv1; mv1 = 0;
            if (flush) begin
                mq.delete();
                movf = 0; munf = 0;
            end else begin
                if (wr_en && mn == 16) movf = 1;
                if (rd_en && mn < 4) munf = 1;
                if (rd_en && mn >= 4) begin
                    for (int k = 0; k < 4; k++) md1[8*k +: 8] = mq.pop_front();
                    mv1 = 1;
                end
                if (wr_en && mn < 16) mq.push_back(wr_data);
            end
        end
    end

    int cn;
    always @(negedge clk) begin
        cn = mq.size();
        chk("wr_level", l_wl, cn);
        chk("rd_level", l_rl, cn / 4);
        chk("wr_full", l_full, cn == 16);
        chk("almost_full", l_af, cn >= 14);
        chk("rd_empty", l_empty, cn < 4);
        chk("almost_empty", l_ae, cn / 4 <= 1);
        chk("overflow", l_ovf, movf);
        chk("underflow", l_unf, munf);
        chk("rd_valid", l_valid, LAT == 1 ? mv1 : mv2);
        chk("rd_data", l_data, LAT == 1 ? md1 : md2);
        chk("msb rd_valid", m_valid, LAT == 1 ? mv1 : mv2);
        chk("msb rd_data", m_data, swap(LAT == 1 ? md1 : md2));
        chk("msb status", {m_full, m_af, m_wl, m_empty, m_ae, m_rl, m_ovf_o, m_unf_o},
            {l_full, l_af, 5'(cn), cn < 4, cn / 4 <= 1, 3'(cn / 4), movf, munf});
    end

    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit f);
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        chk("reset rd_empty", l_empty, 1);
        chk("reset almost_empty", l_ae, 1);
        chk("reset wr_level", l_wl, 0);
        chk("reset rd_data", l_data, 0);
        // Single read word, both packing orders
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0);
        chk("three words still empty", l_empty, 1);
        drive(1, 8'h44, 0, 0);
        chk("fourth word clears empty", l_empty, 0);
        drive(0, 0, 1, 0);
        repeat (LAT - 1) drive(0, 0, 0, 0);
        chk("lsb first data", l_data, 32'h44332211);
        chk("msb first data", m_data, 32'h11223344);
        chk("read valid", l_valid, 1);
        chk("empty after read", l_empty, 1);
        drive(0, 0, 0, 0);
        chk("data held", l_data, 32'h44332211);
        chk("valid drops", l_valid, 0);
        // Fill to full, overflow, drain
        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(8'hA0 + i - 1), 0, 0);
            chk("almost_full ramp", l_af, i >= 14);
        end
        chk("full at 16", l_full, 1);
        drive(1, 8'hFF, 0, 0);
        chk("overflow set", l_ovf, 1);
        chk("dropped write level", l_wl, 16);
        repeat (4) drive(0, 0, 1, 0);
        repeat (LAT - 1) drive(0, 0, 0, 0);
        chk("last drained word", l_data, 32'hAFAEADAC);
        chk("drained level", l_wl, 0);
        chk("overflow sticky", l_ovf, 1);
        // Partial word read, then flush
        drive(0, 0, 0, 1);
        chk("flush clears overflow", l_ovf, 0);
        drive(1, 8'h01, 0, 0);
        drive(1, 8'h02, 0, 0);
        drive(1, 8'h03, 0, 0);
        drive(0, 0, 1, 0);
        repeat (LAT - 1) drive(0, 0, 0, 0);
        chk("partial read no valid", l_valid, 0);
        chk("underflow set", l_unf, 1);
        chk("partial level kept", l_wl, 3);
        drive(0, 0, 0, 1);
        chk("flush level", l_wl, 0);
        chk("flush clears underflow", l_unf, 0);
        // Continuous stream across pointer wrap, reads as soon as a word is complete
        for (int i = 0; i < 100; i++) drive(1, 8'(i), mq.size() >= 4, 0);
        for (int i = 0; i < 8 && mq.size() >= 4; i++) drive(0, 0, 1, 0);
        repeat (LAT) drive(0, 0, 0, 0);
        chk("stream last word", l_data, 32'h63626160);
        chk("stream no overflow", l_ovf, 0);
        chk("stream no underflow", l_unf, 0);
        chk("stream empty", l_wl, 0);
        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) drive(1, 8'(8'h50 + i), 0, 0);
        drive(0, 0, 1, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async rst wr_level", l_wl, 0);
        chk("async rst rd_data", l_data, 0);
        chk("async rst rd_valid", l_valid, 0);
        chk("async rst rd_empty", l_empty, 1);
        @(negedge clk);
        rst_n = 1;
        drive(1, 8'hC1, 0, 0);
        drive(1, 8'hC2, 0, 0);
        drive(1, 8'hC3, 0, 0);
        drive(1, 8'hC4, 0, 0);
        drive(0, 0, 1, 0);
        repeat (LAT - 1) drive(0, 0, 0, 0);
        chk("post reset data", l_data, 32'hC4C3C2C1);
        chk("post reset valid", l_valid, 1);
        drive(0, 0, 0, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/width_conv_fifo.md
# width_conv_fifo

Synchronous FIFO that packs narrow write words into wide read words at a parametrised integer ratio. It generalises the fixed 8-to-256-bit UART receive buffer into a reusable block. It adds both-side water levels, programmable thresholds, packing order, flush, sticky error flags and optional output register. It sits between the UART byte stream and the accelerator's wide weight/feature loaders.

## Interface
Parameters:
- WR_WIDTH, 8: write word width in bits.
- RATIO, 32: write words per read word; power of 2, 2..64. RD_WIDTH = WR_WIDTH*RATIO; LOG_R = log2(RATIO).
- DEPTH_W, 10: write-side address width; capacity 2^DEPTH_W write words; RD_DEPTH_W = DEPTH_W-LOG_R.
- MSB_FIRST, 0: 0 = first written word lands in rd_data[WR_WIDTH-1:0]; 1 = first word lands in the top slice.
- AF_NUM, 1000: almost_full threshold in write words.
- AE_NUM, 4: almost_empty threshold in read words.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset (one clock; reset async active-low, fixed).
- flush  in  1  synchronous clear of contents and error flags.
- wr_en  in  1  write request.
- wr_data  in  WR_WIDTH  write word.
- wr_full  out  1  no write-word space.
- almost_full  out  1  wr_level >= AF_NUM.
- wr_level  out  DEPTH_W+1  stored write words, partial read word included.
- rd_en  in  1  read request.
- rd_data  out  RD_WIDTH  read word.
- rd_valid  out  1  rd_data updated this cycle.
- rd_empty  out  1  no complete read word stored.
- almost_empty  out  1  rd_level <= AE_NUM.
- rd_level  out  RD_DEPTH_W+1  complete read words stored (wr_level >> LOG_R).
- overflow  out  1  sticky: write attempted while wr_full.
- underflow  out  1  sticky: read attempted while rd_empty.

## Operation
- Storage: RATIO banks, each 2^RD_DEPTH_W x WR_WIDTH. Write pointer wp (DEPTH_W+1 bits): low LOG_R bits select bank, upper bits select row. Read pointer rp (RD_DEPTH_W+1 bits) reads all banks at one row.
- wr_level = wp - (rp << LOG_R); wr_full = (wr_level == 2^DEPTH_W); rd_empty = (rd_level == 0).
- Write accepted iff wr_en & !wr_full & !flush; wp increments, wrapping modulo 2^(DEPTH_W+1).
- Read accepted iff rd_en & !rd_empty & !flush; rp increments, rd_data loaded with banks in order per MSB_FIRST.
- Flags are evaluated on pre-edge state. A write while full is dropped even if a read is accepted in the same cycle. A read when only a partial word exists is rejected.
- Simultaneous accepted read and write: both pointers advance; wr_level changes by +1-RATIO.
- flush has priority over wr_en/rd_en: wp=rp=0, overflow=underflow=0; rd_data held; no rd_valid.
- overflow/underflow set on rejected request, cleared only by flush or reset.
- Reset values: wp=rp=0, wr_full=0, almost_full=0 (AF_NUM>0), wr_level=0, rd_empty=1, almost_empty=1, rd_level=0, rd_data=0, rd_valid=0, overflow=underflow=0.

## Timing
- All status outputs are combinational from registered pointers and update the cycle after the causing edge.
- Write-to-empty-deassert: rd_empty falls the cycle after the RATIO-th word of a read word is accepted.
- Read latency: rd_data and rd_valid valid 1 cycle after accepted rd_en; rd_data holds until next accepted read.
- Back-to-back reads every cycle are sustained; writes every cycle are sustained.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; partial words are discarded.

## Configuration
- WCFIFO_OUTPUT_REG_EN defined: extra output register stage; rd_data/rd_valid appear 2 cycles after accepted rd_en; throughput unchanged; the register resets to 0.
- Undefined: 1-cycle read latency as above.

## Test plan
Bench parameters: WR_WIDTH=8, RATIO=4, DEPTH_W=4, AF_NUM=14, AE_NUM=1, MSB_FIRST=0, macro undefined unless stated.
- Write 0x11,0x22,0x33,0x44, then rd_en -> rd_empty falls after 4th write; rd_data=0x44332211 with rd_valid 1 cycle later; rd_empty returns to 1.
- MSB_FIRST=1, same stimulus -> rd_data=0x11223344.
- Write 16 words -> wr_full=1, almost_full=1 from word 14. 17th write -> dropped, overflow=1. Read all 4 -> data intact, wr_level=0.
- rd_en when wr_level=3 -> no rd_valid, underflow=1, wr_level stays 3. flush -> wr_level=0, underflow=0.
- Continuous writes and reads for 100 words across pointer wrap -> read stream matches scoreboard, no flag errors.
- WCFIFO_OUTPUT_REG_EN defined; assert rst_n low mid-stream -> all outputs at reset values. Subsequent reads show 2-cycle latency.
